fifo_serial_tx: RTL and testbench
=================================

// Module: fifo_serial_tx
// PURPOSE
//  Read-side consumer for the byte FIFO: pops bytes through the FIFO read port (r_en/buff_out/buff_empty).
//  Sends each byte as an 8N1 serial frame: start bit, 8 data bits LSB first, one stop bit.
//  Sits between the FIFO read port and an external serial line; owns the FIFO read strobe.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit (legal range >=2)
//  DATA_W        8   FIFO word / frame data width
//  CNT_W         8   width of the transmitted-byte counter
// PORTS
//  clk          in   1       single clock; all logic on posedge clk
//  rst          in   1       reset, synchronous, active-high
//  enable       in   1       permission to start new frames
//  buff_empty   in   1       FIFO empty flag
//  buff_out     in   DATA_W  FIFO read data; valid the cycle after the edge that samples r_en=1
//  r_en         out  1       FIFO read strobe; registered; exactly one cycle wide per byte
//  tx           out  1       serial line; idle high
//  busy         out  1       high in every state except IDLE
//  byte_cnt     out  CNT_W   count of completed frames; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, tx=1, r_en=0, busy=0, byte_cnt=0, shift reg=0, bit/baud counters=0.
//   Reset has priority over all other inputs.
//  Reset mid-frame: the byte is abandoned and tx=1 from the next edge.
//   A pop already issued is not replayed: that byte is lost.
//  FSM states: IDLE, POP, LOAD, START, DATA, STOP.
//  IDLE -> POP when enable=1 && buff_empty=0 at edge k; r_en<=1. Otherwise stay in IDLE with r_en=0.
//  POP -> LOAD at edge k+1 (the FIFO samples r_en here); r_en<=0.
//  LOAD -> START at edge k+2: shift<=buff_out, tx<=0, baud counter cleared.
//  START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
//  DATA: each bit held CLKS_PER_BIT cycles, LSB first. After DATA_W bits: tx<=1, go to STOP.
//  STOP: tx=1 for CLKS_PER_BIT cycles; on the final edge byte_cnt<=byte_cnt+1 and state<=IDLE.
//  Start bit falls at edge k+2 and the frame spans (DATA_W+2)*CLKS_PER_BIT cycles.
//  Back-to-back: with the FIFO non-empty and enable=1, start-to-start is exactly (DATA_W+2)*CLKS_PER_BIT+3 cycles.
//  enable and buff_empty are sampled only in IDLE:
//   - enable dropping mid-frame: the current frame completes and no further r_en is issued.
//   - buff_empty changing mid-frame: no effect on the current frame.
//  r_en is never asserted unless buff_empty=0 was sampled at the preceding IDLE edge.
//   Never two r_en pulses per frame.
//  Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every bit boundary.
//   Bit index: 0..DATA_W-1.
//  byte_cnt: modulo 2^CNT_W; no saturation.
//  Illegal or unreachable state encodings return to IDLE with tx=1 on the next edge.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1 Reset: rst=1 for 2 cycles, any inputs -> tx=1, r_en=0, busy=0, byte_cnt=0.
//  2 Single byte: FIFO holds 0xA5, enable=1 -> one r_en pulse; tx=0 for 4 cycles;
//    then 1,0,1,0,0,1,0,1, 4 cycles each; then tx=1; byte_cnt=1; busy low after 40 cycles of frame.
//  3 Empty FIFO: buff_empty=1, enable=1 for 200 cycles -> r_en never 1, tx stays 1, busy=0.
//  4 Burst: FIFO holds 0x00,0xFF,0x3C -> three frames, start bits exactly 43 cycles apart,
//    correct bit patterns, byte_cnt=3, then IDLE.
//  5 enable deasserted during DATA bit 3 with FIFO non-empty -> frame finishes intact, no further r_en,
//    byte_cnt increments by 1 only.
//  6 rst pulsed during DATA bit 5 -> next edge tx=1, busy=0, byte_cnt=0.
//    Then 256 frames with CLKS_PER_BIT=2 -> byte_cnt wraps to 0.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// FIFO read-side consumer: pops one byte at a time and shifts it out as an 8N1 frame.
// The FIFO read strobe is owned here and is issued at most once per frame.
module fifo_serial_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              buff_empty,
   input  logic [DATA_W-1:0] buff_out,
   output logic              r_en,
   output logic              tx,
   output logic              busy,
   output logic [CNT_W-1:0]  byte_cnt
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic                tx_q, tx_d;
   logic                r_en_q, r_en_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic baud_end;
   logic bit_end;
   logic can_pop;

   assign baud_end = (baud_q == BAUD_LAST);
   assign bit_end  = (bit_q == BIT_LAST);
   assign can_pop  = enable && !buff_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         r_en_q  <= 1'b0;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         r_en_q  <= r_en_d;
         shift_q <= shift_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (can_pop) state_d = S_POP;
         S_POP:   state_d = S_LOAD;
         S_LOAD:  state_d = S_START;
         S_START: if (baud_end) state_d = S_DATA;
         S_DATA:  if (baud_end && bit_end) state_d = S_STOP;
         S_STOP:  if (baud_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; every bit boundary clears the baud counter.
   always_comb begin
      tx_d    = tx_q;
      r_en_d  = 1'b0;
      shift_d = shift_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            bit_d  = '0;
            r_en_d = can_pop;
         end
         S_POP: begin
            tx_d = 1'b1;
         end
         S_LOAD: begin
            // buff_out is valid here: the FIFO sampled r_en on the previous edge.
            shift_d = buff_out;
            tx_d    = 1'b0;
            baud_d  = '0;
         end
         S_START: begin
            if (baud_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_end) begin
                  tx_d = 1'b1;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_end) begin
               baud_d = '0;
               cnt_d  = cnt_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            tx_d   = 1'b1;
            baud_d = '0;
            bit_d  = '0;
         end
      endcase
   end

   assign r_en     = r_en_q;
   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE);
   assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: small FIFO model on the read port, frame decoder on tx,
// plus a second instance at two clocks per bit for the byte counter wrap.
module tb_fifo_serial_tx;

   localparam int CPB  = 4;
   localparam int CPB2 = 2;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       buff_empty;
   logic [7:0] buff_out;
   logic       r_en;
   logic       tx;
   logic       busy;
   logic [7:0] byte_cnt;

   logic       rst2;
   logic       enable2;
   logic       buff_empty2;
   logic [7:0] buff_out2;
   logic       r_en2;
   logic       tx2;
   logic       busy2;
   logic [7:0] byte_cnt2;

   logic [7:0] mem [0:15];
   int         wp = 0;
   int         rp = 0;
   logic       ovr = 1'b0;
   logic       ovr_val = 1'b0;
   int         pops2 = 0;
   int         cyc = 0;
   int         rcount = 0;
   int         rwide = 0;
   logic       r_en_prev = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .buff_empty(buff_empty), .buff_out(buff_out),
      .r_en(r_en), .tx(tx), .busy(busy), .byte_cnt(byte_cnt)
   );

   fifo_serial_tx #(.CLKS_PER_BIT(CPB2), .DATA_W(8), .CNT_W(8)) dut2 (
      .clk(clk), .rst(rst2), .enable(enable2), .buff_empty(buff_empty2), .buff_out(buff_out2),
      .r_en(r_en2), .tx(tx2), .busy(busy2), .byte_cnt(byte_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign buff_empty  = ovr ? ovr_val : (rp == wp);
   assign buff_empty2 = (pops2 >= 256);

   // FIFO models: data appears the cycle after the edge that samples r_en=1.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (r_en) begin
         buff_out <= mem[rp[3:0]];
         rp       <= rp + 1;
      end
      if (r_en2) begin
         buff_out2 <= pops2[7:0];
         pops2     <= pops2 + 1;
      end
   end

   always @(posedge clk) begin
      if (r_en) rcount++;
      if (r_en && r_en_prev) rwide++;
      r_en_prev = r_en;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp[3:0]] = b;
      wp++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] exp, input int drop_bit,
                              output int t_start);
      logic [9:0] got;
      logic       stable;
      logic       v;
      logic       busy_last;
      int         n;
      n = 0;
      while (tx !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start_seen"}, 32'(tx), 32'd0);
      t_start   = cyc;
      stable    = 1'b1;
      got       = '0;
      busy_last = 1'b0;
      for (int b = 0; b < 10; b++) begin
         if (b == drop_bit) enable = 1'b0;
         v = tx;
         for (int c = 0; c < CPB; c++) begin
            if (tx !== v) stable = 1'b0;
            if (b == 9 && c == CPB - 1) busy_last = busy;
            @(negedge clk);
         end
         got[b] = v;
      end
      chk({tag, "_bits"}, 32'(got), 32'({1'b1, exp, 1'b0}));
      chk({tag, "_stable"}, 32'(stable), 32'd1);
      chk({tag, "_busy_in_stop"}, 32'(busy_last), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r_cyc, t1, t2, t3, rc0, n;
      logic seen_low, seen_busy;

      rst = 1'b1;
      rst2 = 1'b1;
      enable = 1'b1;
      enable2 = 1'b0;
      ovr = 1'b1;
      ovr_val = 1'b0;
      buff_out = 8'h00;
      buff_out2 = 8'h00;

      // 1: reset with enable=1 and a non-empty flag
      repeat (2) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_r_en", 32'(r_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("rst2_tx", 32'(tx2), 32'd1);
      chk("rst2_byte_cnt", 32'(byte_cnt2), 32'd0);
      enable = 1'b0;
      ovr = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // 2: single byte 0xA5
      push(8'hA5);
      enable = 1'b1;
      n = 0;
      while (r_en !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("single_r_en_seen", 32'(r_en), 32'd1);
      r_cyc = cyc;
      @(negedge clk);
      chk("single_r_en_width", 32'(r_en), 32'd0);
      check_frame("single", 8'hA5, -1, t1);
      chk("single_pop_to_start", 32'(t1 - r_cyc), 32'd2);
      chk("single_busy_after", 32'(busy), 32'd0);
      chk("single_byte_cnt", 32'(byte_cnt), 32'd1);
      chk("single_r_en_count", 32'(rcount), 32'd1);

      // 3: empty FIFO with enable held
      rc0 = rcount;
      seen_low = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
         if (busy !== 1'b0) seen_busy = 1'b1;
      end
      chk("empty_no_r_en", 32'(rcount - rc0), 32'd0);
      chk("empty_tx_idle", 32'(seen_low), 32'd0);
      chk("empty_not_busy", 32'(seen_busy), 32'd0);

      // 4: burst of three
      enable = 1'b0;
      do_reset();
      rc0 = rcount;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      enable = 1'b1;
      check_frame("burst0", 8'h00, -1, t1);
      check_frame("burst1", 8'hFF, -1, t2);
      check_frame("burst2", 8'h3C, -1, t3);
      chk("burst_gap01", 32'(t2 - t1), 32'd43);
      chk("burst_gap12", 32'(t3 - t2), 32'd43);
      repeat (4) @(negedge clk);
      chk("burst_byte_cnt", 32'(byte_cnt), 32'd3);
      chk("burst_idle", 32'(busy), 32'd0);
      chk("burst_r_en_count", 32'(rcount - rc0), 32'd3);

      // 5: enable dropped during data bit 3 with data still queued
      enable = 1'b0;
      do_reset();
      rc0 = rcount;
      push(8'h5A);
      push(8'hC3);
      enable = 1'b1;
      check_frame("endrop", 8'h5A, 4, t1);
      seen_busy = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) seen_busy = 1'b1;
      end
      chk("endrop_r_en_count", 32'(rcount - rc0), 32'd1);
      chk("endrop_byte_cnt", 32'(byte_cnt), 32'd1);
      chk("endrop_stays_idle", 32'(seen_busy), 32'd0);

      // 6: reset pulsed during data bit 5 of 0xC3
      enable = 1'b1;
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_start_seen", 32'(tx), 32'd0);
      repeat (6 * CPB + 1) @(negedge clk);
      chk("midrst_tx_bit5", 32'(tx), 32'd0);
      chk("midrst_cnt_before", 32'(byte_cnt), 32'd1);
      rst = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx", 32'(tx), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("midrst_r_en", 32'(r_en), 32'd0);
      chk("r_en_single_cycle", 32'(rwide), 32'd0);

      // Counter wrap on the two-clocks-per-bit instance
      rst2 = 1'b0;
      enable2 = 1'b1;
      n = 0;
      while (pops2 < 256 && n < 7000) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_pops", 32'(pops2), 32'd256);
      chk("wrap_cnt_at_last_pop", 32'(byte_cnt2), 32'd255);
      n = 0;
      while (busy2 !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_idle", 32'(busy2), 32'd0);
      chk("wrap_byte_cnt", 32'(byte_cnt2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
